// File: rtl/fishing_game_ctrl_if.sv
// Player controls in, rod/hook/fish/score state out.
// tick gates all game-state updates to the frame rate.
interface fishing_game_ctrl_if;
  logic       tick;
  logic       up;
  logic       left;
  logic       right;
  logic [9:0] rod_x;
  logic [9:0] hook_y;
  logic [9:0] fish_x;
  logic [9:0] fish_y;
  logic [4:0] fish_half_h;
  logic       fish_visible;
  logic [2:0] level;
  logic [3:0] score;
  logic [1:0] misses;
  logic [1:0] game_state;

  modport master (
    output tick, up, left, right,
    input  rod_x, hook_y, fish_x, fish_y,
    input  fish_half_h, fish_visible,
    input  level, score, misses, game_state
  );

  modport slave (
    input  tick, up, left, right,
    output rod_x, hook_y, fish_x, fish_y,
    output fish_half_h, fish_visible,
    output level, score, misses, game_state
  );
endinterface

// File: rtl/fishing_game_ctrl.sv
// Fishing game controller: rod, hook, fish motion,
// catch/escape/landing rules and win/lose handling.
module fishing_game_ctrl #(
  parameter int N_LEVELS    = 4,
  parameter int BOTTOM_Y    = 470,
  parameter int LEVEL_STEP  = 90,
  parameter int SURFACE_Y   = 106,
  parameter int X_RIGHT     = 798,
  parameter int X_LEFT      = 144,
  parameter int ROD_MIN     = 312,
  parameter int ROD_MAX     = 778,
  parameter int ROD_STEP    = 3,
  parameter int SINK_STEP   = 4,
  parameter int REEL_STEP   = 2,
  parameter int FISH_SPEED  = 2,
  parameter int SPAWN_DELAY = 400,
  parameter int HIT_W0      = 16,
  parameter int HALF_H0     = 10,
  parameter int SLACK_LIMIT = 60,
  parameter int MAX_MISSES  = 3
) (
  input logic clk,
  input logic rst,
  fishing_game_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_FISH  = 2'b00,
    S_CATCH = 2'b01,
    S_WIN   = 2'b10,
    S_LOSE  = 2'b11
  } state_t;

  localparam logic [9:0] ROD_RST  = 10'd450;
  localparam logic [9:0] HOOK_RST = 10'd155;

  state_t     state_q, state_d;
  logic [9:0] rod_q, rod_d;
  logic [9:0] hook_q, hook_d;
  logic [9:0] fx_q, fx_d;
  logic [9:0] fy_q, fy_d;
  logic [8:0] tmr_q, tmr_d;
  logic [6:0] slack_q, slack_d;
  logic [2:0] lvl_q, lvl_d;
  logic [3:0] score_q, score_d;
  logic [1:0] miss_q, miss_d;

  logic [9:0] row, row_nx, hit_w, dy;
  logic [4:0] half_h;
  logic       at_delay, in_x, hook_ev;

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  always_comb begin
    row      = 10'(BOTTOM_Y - LEVEL_STEP * int'(lvl_q));
    row_nx   = 10'(BOTTOM_Y - LEVEL_STEP * (int'(lvl_q) + 1));
    hit_w    = 10'(max1(HIT_W0 >> lvl_q));
    half_h   = 5'(max1(HALF_H0 >> lvl_q));
    at_delay = int'(tmr_q) >= SPAWN_DELAY;
    dy       = (hook_q >= fy_q) ? hook_q - fy_q
                                : fy_q - hook_q;
    in_x     = (rod_q >= fx_q) &&
               ({1'b0, rod_q} <=
                {1'b0, fx_q} + {1'b0, hit_w});
    hook_ev  = bus.up && at_delay && in_x &&
               (dy <= {5'd0, half_h});
  end

  always_comb begin
    state_d = state_q;
    rod_d   = rod_q;
    hook_d  = hook_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    tmr_d   = tmr_q;
    slack_d = slack_q;
    lvl_d   = lvl_q;
    score_d = score_q;
    miss_d  = miss_q;
    unique case (state_q)
      S_FISH: if (bus.tick) begin
        if (bus.right) begin
          if (int'(rod_q) <= ROD_MAX - ROD_STEP)
            rod_d = rod_q + 10'(ROD_STEP);
        end else if (bus.left) begin
          if (int'(rod_q) >= ROD_MIN + ROD_STEP)
            rod_d = rod_q - 10'(ROD_STEP);
        end
        if (int'(hook_q) + SINK_STEP >= int'(row))
          hook_d = row;
        else
          hook_d = hook_q + 10'(SINK_STEP);
        // a hook beats a simultaneous wrap
        if (hook_ev) begin
          state_d = S_CATCH;
          tmr_d   = '0;
          slack_d = '0;
        end else if (!at_delay) begin
          if (bus.left || bus.right)
            tmr_d = tmr_q + 9'd1;
          fx_d = 10'(X_RIGHT);
        end else if (int'(fx_q) <= X_LEFT + FISH_SPEED) begin
          fx_d  = 10'(X_RIGHT);
          tmr_d = '0;
        end else begin
          fx_d = fx_q - 10'(FISH_SPEED);
        end
      end
      S_CATCH: if (bus.tick) begin
        // landing beats a simultaneous slack expiry
        if (int'(fy_q) < SURFACE_Y) begin
          score_d = (score_q == 4'hf) ? score_q
                                      : score_q + 4'd1;
          if (int'(lvl_q) == N_LEVELS - 1) begin
            state_d = S_WIN;
          end else begin
            state_d = S_FISH;
            lvl_d   = lvl_q + 3'd1;
            fy_d    = row_nx;
            fx_d    = 10'(X_RIGHT);
            tmr_d   = '0;
          end
        end else if (bus.up) begin
          fy_d    = (int'(fy_q) >= REEL_STEP) ?
                    fy_q - 10'(REEL_STEP) : '0;
          hook_d  = (int'(hook_q) >= REEL_STEP) ?
                    hook_q - 10'(REEL_STEP) : '0;
          slack_d = '0;
        end else if (int'(slack_q) + 1 >= SLACK_LIMIT) begin
          miss_d  = miss_q + 2'd1;
          state_d = (int'(miss_q) + 1 >= MAX_MISSES) ?
                    S_LOSE : S_FISH;
          fy_d    = row;
          fx_d    = 10'(X_RIGHT);
          tmr_d   = '0;
          slack_d = '0;
        end else begin
          slack_d = slack_q + 7'd1;
        end
      end
      S_WIN, S_LOSE:
        if (bus.tick && (bus.left || bus.right)) begin
          state_d = S_FISH;
          lvl_d   = '0;
          score_d = '0;
          miss_d  = '0;
          tmr_d   = '0;
          slack_d = '0;
          hook_d  = HOOK_RST;
          fy_d    = 10'(BOTTOM_Y);
          fx_d    = 10'(X_RIGHT);
        end
      default: state_d = S_FISH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FISH;
      rod_q   <= ROD_RST;
      hook_q  <= HOOK_RST;
      fx_q    <= 10'(X_RIGHT);
      fy_q    <= 10'(BOTTOM_Y);
      tmr_q   <= '0;
      slack_q <= '0;
      lvl_q   <= '0;
      score_q <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      rod_q   <= rod_d;
      hook_q  <= hook_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      tmr_q   <= tmr_d;
      slack_q <= slack_d;
      lvl_q   <= lvl_d;
      score_q <= score_d;
      miss_q  <= miss_d;
    end
  end

  assign bus.rod_x        = rod_q;
  assign bus.hook_y       = hook_q;
  assign bus.fish_x       = (state_q == S_CATCH) ? rod_q : fx_q;
  assign bus.fish_y       = fy_q;
  assign bus.fish_half_h  = half_h;
  assign bus.fish_visible = (state_q == S_CATCH) ||
                            ((state_q == S_FISH) && at_delay);
  assign bus.level        = lvl_q;
  assign bus.score        = score_q;
  assign bus.misses       = miss_q;
  assign bus.game_state   = state_q;

endmodule

// File: tb/tb_fishing_game_ctrl.sv
// Directed bench for fishing_game_ctrl: spawn, hook,
// reel, escape, lose, win and mid-catch reset.
module tb_fishing_game_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_run  = 0;
  int   n_fail = 0;
  int   rows[4] = '{470, 380, 290, 200};
  int   hh[4]   = '{10, 5, 2, 1};

  fishing_game_ctrl_if bus();

  fishing_game_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got,
                       input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic step(input logic u, l, r);
    bus.tick  = 1'b1;
    bus.up    = u;
    bus.left  = l;
    bus.right = r;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic u, l, r);
    repeat (n) step(u, l, r);
  endtask

  task automatic hook_at(input int idle);
    run(400, 1'b0, 1'b0, 1'b1);
    run(idle, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_reset(input string p);
    check({p, "_state"}, int'(bus.game_state), 0);
    check({p, "_level"}, int'(bus.level), 0);
    check({p, "_score"}, int'(bus.score), 0);
    check({p, "_misses"}, int'(bus.misses), 0);
    check({p, "_rod"}, int'(bus.rod_x), 450);
    check({p, "_hook"}, int'(bus.hook_y), 155);
    check({p, "_fx"}, int'(bus.fish_x), 798);
    check({p, "_fy"}, int'(bus.fish_y), 470);
    check({p, "_vis"}, int'(bus.fish_visible), 0);
  endtask

  task automatic land_level(input int lvl);
    hook_at(11);
    check($sformatf("hook_l%0d", lvl),
          int'(bus.game_state), 1);
    run((rows[lvl] - 104) / 2, 1'b1, 1'b0, 1'b0);
    check($sformatf("reel_fy_l%0d", lvl),
          int'(bus.fish_y), 104);
    step(1'b1, 1'b0, 1'b0);
    check($sformatf("land_score_l%0d", lvl),
          int'(bus.score), lvl + 1);
    if (lvl < 3) begin
      check($sformatf("land_lvl_l%0d", lvl),
            int'(bus.level), lvl + 1);
      check($sformatf("land_fy_l%0d", lvl),
            int'(bus.fish_y), rows[lvl + 1]);
      check($sformatf("land_st_l%0d", lvl),
            int'(bus.game_state), 0);
    end
  endtask

  initial begin
    bus.tick  = 1'b1;
    bus.up    = 1'b1;
    bus.left  = 1'b0;
    bus.right = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst0");
    rst = 1'b1;

    bus.tick = 1'b0;
    bus.up   = 1'b0;
    @(posedge clk);
    #1;
    check("no_tick_rod", int'(bus.rod_x), 450);

    run(400, 1'b0, 1'b0, 1'b1);
    check("sat_rod", int'(bus.rod_x), 777);
    check("spawn_vis", int'(bus.fish_visible), 1);
    check("spawn_fx", int'(bus.fish_x), 798);
    check("sink_hook", int'(bus.hook_y), 470);
    run(326, 1'b0, 1'b0, 1'b0);
    check("edge_fx", int'(bus.fish_x), 146);
    step(1'b0, 1'b0, 1'b0);
    check("wrap_fx", int'(bus.fish_x), 798);
    check("wrap_vis", int'(bus.fish_visible), 0);

    hook_at(13);
    check("b_hook_st", int'(bus.game_state), 1);
    check("b_catch_fx", int'(bus.fish_x), 777);
    run(183, 1'b1, 1'b0, 1'b0);
    check("b_reel_fy", int'(bus.fish_y), 104);
    check("b_reel_hook", int'(bus.hook_y), 104);
    check("b_reel_st", int'(bus.game_state), 1);
    step(1'b1, 1'b0, 1'b0);
    check("b_land_lvl", int'(bus.level), 1);
    check("b_land_score", int'(bus.score), 1);
    check("b_land_fy", int'(bus.fish_y), 380);
    check("b_land_st", int'(bus.game_state), 0);

    for (int i = 0; i < 3; i++) begin
      hook_at(13);
      check($sformatf("c_hook%0d", i),
            int'(bus.game_state), 1);
      if (i == 0) begin
        step(1'b0, 1'b1, 1'b0);
        check("c_rod_hold", int'(bus.rod_x), 777);
        run(58, 1'b0, 1'b0, 1'b0);
      end else begin
        run(59, 1'b0, 1'b0, 1'b0);
      end
      check($sformatf("c_slack59_%0d", i),
            int'(bus.game_state), 1);
      step(1'b0, 1'b0, 1'b0);
      check($sformatf("c_miss%0d", i),
            int'(bus.misses), i + 1);
      check($sformatf("c_lvl%0d", i), int'(bus.level), 1);
      if (i < 2) begin
        check($sformatf("c_st%0d", i),
              int'(bus.game_state), 0);
        check($sformatf("c_fy%0d", i),
              int'(bus.fish_y), 380);
        check($sformatf("c_fx%0d", i),
              int'(bus.fish_x), 798);
      end else begin
        check("c_lose", int'(bus.game_state), 3);
      end
    end
    step(1'b0, 1'b1, 1'b0);
    check("r_state", int'(bus.game_state), 0);
    check("r_level", int'(bus.level), 0);
    check("r_score", int'(bus.score), 0);
    check("r_misses", int'(bus.misses), 0);
    check("r_hook", int'(bus.hook_y), 155);
    check("r_fy", int'(bus.fish_y), 470);
    check("r_rod", int'(bus.rod_x), 777);

    for (int lvl = 0; lvl < 4; lvl++) begin
      check($sformatf("half_h_l%0d", lvl),
            int'(bus.fish_half_h), hh[lvl]);
      if (lvl == 3) begin
        run(400, 1'b0, 1'b0, 1'b1);
        run(12, 1'b0, 1'b0, 1'b0);
        check("d_fx774", int'(bus.fish_x), 774);
        step(1'b1, 1'b0, 1'b0);
        check("d_off_by_one", int'(bus.game_state), 0);
        run(313, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("d_rewrap", int'(bus.fish_visible), 0);
      end
      land_level(lvl);
    end
    check("win_state", int'(bus.game_state), 2);
    check("win_score", int'(bus.score), 4);
    check("win_vis", int'(bus.fish_visible), 0);

    step(1'b0, 1'b1, 1'b0);
    check("e_restart", int'(bus.game_state), 0);
    land_level(0);
    land_level(1);
    hook_at(11);
    check("e_hook_l2", int'(bus.game_state), 1);
    run(10, 1'b1, 1'b0, 1'b0);
    check("e_fy", int'(bus.fish_y), 270);
    rst = 1'b0;
    #2;
    check("e_noedge_st", int'(bus.game_state), 1);
    check("e_noedge_lvl", int'(bus.level), 2);
    check("e_noedge_fy", int'(bus.fish_y), 270);
    bus.tick  = 1'b1;
    bus.up    = 1'b1;
    bus.right = 1'b1;
    @(posedge clk);
    #1;
    check_reset("rst1");
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
